// File: rtl/led_pio_pkg.sv
// Register map and STATUS field layout shared by the LED PWM output block.
// Pure constants; no latency, no backpressure.
package led_pio_pkg;

   localparam logic [2:0] ADDR_DATA         = 3'd0;
   localparam logic [2:0] ADDR_SET          = 3'd1;
   localparam logic [2:0] ADDR_CLEAR        = 3'd2;
   localparam logic [2:0] ADDR_DUTY         = 3'd3;
   localparam logic [2:0] ADDR_BLINK_MASK   = 3'd4;
   localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS       = 3'd6;

   localparam int STATUS_CNT_LSB = 0;

   // phase sits directly above the pwm counter field
   function automatic int status_phase_bit(input int pwm_bits);
      return STATUS_CNT_LSB + pwm_bits;
   endfunction

endpackage

// File: rtl/led_pwm_output_if.sv
// Avalon-MM slave bus for the LED PWM output block; zero wait states,
// combinational readdata, no backpressure.
interface led_pwm_output_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, free-running pwm_cnt and a one-cycle wrap strobe.
// Outputs are registered counts plus combinational strobe; never stalls.
module led_pwm_timebase #(
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                wrap
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] ps;
   logic            tick;

   assign tick = (ps == PS_W'(PRESCALE - 1));
   assign wrap = tick & (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ps      <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         ps      <= '0;
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end else begin
         ps      <= ps + PS_W'(1);
      end
   end

endmodule

// File: rtl/led_pwm_output.sv
// LED PIO with set/clear, global PWM dimming and optional blink (LED_PWM_OUTPUT_BLINK_EN).
// One cycle from register/state change to out_port; zero-wait-state slave, no backpressure.
module led_pwm_output
   import led_pio_pkg::*;
#(
   parameter int WIDTH      = 3,
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE   = 1,
   parameter int BLINK_BITS = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   led_pwm_output_if.slave  bus,
   output logic [WIDTH-1:0] out_port
);

   logic                wr;
   logic [WIDTH-1:0]    wd_bits;
   logic [WIDTH-1:0]    data;
   logic [PWM_BITS-1:0] duty_pend;
   logic [PWM_BITS-1:0] duty_act;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                wrap;
   logic                phase;
   logic                pwm_on;
   logic [WIDTH-1:0]    blink_gate;
   logic                unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign wd_bits   = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;

   led_pwm_timebase #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk     (clk),
      .reset_n (reset_n),
      .pwm_cnt (pwm_cnt),
      .wrap    (wrap)
   );

   // duty_act only moves at the period boundary, so a write never truncates a pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data      <= '0;
         duty_pend <= '1;
         duty_act  <= '1;
      end else begin
         if (wrap)
            duty_act <= duty_pend;
         if (wr) begin
            case (bus.address)
               ADDR_DATA:  data      <= wd_bits;
               ADDR_SET:   data      <= data | wd_bits;
               ADDR_CLEAR: data      <= data & ~wd_bits;
               ADDR_DUTY:  duty_pend <= bus.writedata[PWM_BITS-1:0];
               default:    ;
            endcase
         end
      end
   end

`ifdef LED_PWM_OUTPUT_BLINK_EN
   logic [WIDTH-1:0]      blink_mask;
   logic [BLINK_BITS-1:0] blink_period;
   logic [BLINK_BITS-1:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_mask   <= '0;
         blink_period <= '0;
         blink_cnt    <= '0;
         phase        <= 1'b1;
      end else begin
         if (wr && bus.address == ADDR_BLINK_MASK)
            blink_mask <= wd_bits;
         // a period write restarts the blink cycle even on a terminal-count wrap
         if (wr && bus.address == ADDR_BLINK_PERIOD) begin
            blink_period <= bus.writedata[BLINK_BITS-1:0];
            blink_cnt    <= '0;
            phase        <= 1'b1;
         end else if (wrap) begin
            if (blink_period == '0) begin
               blink_cnt <= '0;
               phase     <= 1'b1;
            end else if (blink_cnt == blink_period - BLINK_BITS'(1)) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + BLINK_BITS'(1);
            end
         end
      end
   end

   assign blink_gate = ~blink_mask | {WIDTH{phase}};
`else
   logic [BLINK_BITS-1:0] unused_blink;

   assign unused_blink = '0;
   assign phase        = 1'b1;
   assign blink_gate   = '1;
`endif

   assign pwm_on = (duty_act == '1) | (pwm_cnt < duty_act);

   always_ff @(posedge clk) begin
      if (!reset_n)
         out_port <= '0;
      else
         out_port <= data & {WIDTH{pwm_on}} & blink_gate;
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA, ADDR_SET, ADDR_CLEAR: bus.readdata = 32'(data);
         ADDR_DUTY:                       bus.readdata = 32'(duty_pend);
`ifdef LED_PWM_OUTPUT_BLINK_EN
         ADDR_BLINK_MASK:                 bus.readdata = 32'(blink_mask);
         ADDR_BLINK_PERIOD:               bus.readdata = 32'(blink_period);
`else
         ADDR_BLINK_MASK:                 bus.readdata = '0;
         ADDR_BLINK_PERIOD:               bus.readdata = '0;
`endif
         ADDR_STATUS: bus.readdata = (32'(phase) << status_phase_bit(PWM_BITS))
                                   | (32'(pwm_cnt) << STATUS_CNT_LSB);
         default:     bus.readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_led_pwm_output.sv
// Bench for led_pwm_output: register vector table, PWM/blink corner sequences and
// randomized bus traffic checked against a period-arithmetic reference model.
module tb_led_pwm_output;

   localparam int WIDTH      = 3;
   localparam int PWM_BITS   = 8;
   localparam int PRESCALE   = 1;
   localparam int BLINK_BITS = 16;
   localparam int PER        = 256 * PRESCALE;
`ifdef LED_PWM_OUTPUT_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] out_port;

   led_pwm_output_if bus ();

   led_pwm_output #(
      .WIDTH      (WIDTH),
      .PWM_BITS   (PWM_BITS),
      .PRESCALE   (PRESCALE),
      .BLINK_BITS (BLINK_BITS)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // reference model: time is the number of active edges since reset
   int          k;
   int          w0;
   logic [2:0]  m_data, m_mask, m_out;
   logic [7:0]  m_pend, m_act;
   logic [15:0] m_period;

   function automatic int m_cnt();
      return (k / PRESCALE) % 256;
   endfunction

   function automatic bit m_phase();
      if (!BLINK || m_period == 16'd0) return 1'b1;
      return ((((k / PER) - w0) / int'(m_period)) % 2) == 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2: return 32'(m_data);
         3'd3:             return 32'(m_pend);
         3'd4:             return BLINK ? 32'(m_mask) : 32'd0;
         3'd5:             return BLINK ? 32'(m_period) : 32'd0;
         3'd6:             return 32'(m_cnt()) | (32'(m_phase()) << 8);
         default:          return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      bit on;
      if (!reset_n) begin
         k = 0; w0 = 0;
         m_data = 0; m_mask = 0; m_out = 0;
         m_pend = 8'hFF; m_act = 8'hFF; m_period = 0;
         return;
      end
      on    = (m_act == 8'hFF) || (m_cnt() < int'(m_act));
      m_out = m_data & {3{on}} & (~m_mask | {3{m_phase()}});
      if ((k + 1) % PER == 0) m_act = m_pend;
      k++;
      if (bus.chipselect && !bus.write_n) begin
         case (bus.address)
            3'd0: m_data = bus.writedata[2:0];
            3'd1: m_data = m_data | bus.writedata[2:0];
            3'd2: m_data = m_data & ~bus.writedata[2:0];
            3'd3: m_pend = bus.writedata[7:0];
            3'd4: if (BLINK) m_mask = bus.writedata[2:0];
            3'd5: if (BLINK) begin m_period = bus.writedata[15:0]; w0 = k / PER; end
            default: ;
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("out_port", 32'(out_port), 32'(m_out));
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      cyc();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      bus.address = a;
      #1;
      chk(name, bus.readdata, exp);
   endtask

   task automatic sync_cnt(input int t);
      for (int i = 0; i < PER + 2 && m_cnt() != t; i++) cyc();
   endtask

   task automatic count_on(output int n);
      n = 0;
      for (int i = 0; i < PER; i++) begin
         cyc();
         if (out_port != 3'b000) n++;
      end
   endtask

   typedef struct {
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [2:0]  ra;
      logic [31:0] er;
      logic [2:0]  eo;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int n;
      logic [2:0] a;
      tbl[0]  = '{3'd0, 32'h5,        3'd0, 32'h5, 3'd5};
      tbl[1]  = '{3'd1, 32'h2,        3'd0, 32'h7, 3'd7};
      tbl[2]  = '{3'd2, 32'h4,        3'd0, 32'h3, 3'd3};
      tbl[3]  = '{3'd1, 32'h0,        3'd1, 32'h3, 3'd3};
      tbl[4]  = '{3'd2, 32'h0,        3'd2, 32'h3, 3'd3};
      tbl[5]  = '{3'd3, 32'h40,       3'd3, 32'h40, 3'd3};
      tbl[6]  = '{3'd0, 32'hFFFFFFF8, 3'd0, 32'h0, 3'd0};
      tbl[7]  = '{3'd0, 32'h7,        3'd0, 32'h7, 3'd7};
      tbl[8]  = '{3'd7, 32'h123,      3'd7, 32'h0, 3'd7};
      tbl[9]  = '{3'd6, 32'hFFFF,     3'd0, 32'h7, 3'd7};
      tbl[10] = '{3'd4, 32'h7,        3'd4, BLINK ? 32'h7 : 32'h0, 3'd7};
      tbl[11] = '{3'd5, 32'h0,        3'd5, 32'h0, 3'd7};
      tbl[12] = '{3'd3, 32'hABCD12FF, 3'd3, 32'hFF, 3'd7};

      bus.address = 3'd0; bus.writedata = 32'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
      reset_n = 1'b0;
      cyc();
      cyc();
      chk("reset out_port", 32'(out_port), 32'd0);
      rd(3'd3, 32'hFF,  "reset DUTY");
      rd(3'd0, 32'h0,   "reset DATA");
      rd(3'd6, 32'h100, "reset STATUS");
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         wr(tbl[i].wa, tbl[i].wd);
         cyc();
         rd(tbl[i].ra, tbl[i].er, $sformatf("table[%0d] readdata", i));
         chk($sformatf("table[%0d] out_port", i), 32'(out_port), 32'(tbl[i].eo));
      end

      // duty update waits for the wrap, then 64/256 on
      wr(3'd4, 32'h0);
      sync_cnt(0);
      sync_cnt(8'h80);
      wr(3'd3, 32'h40);
      n = 0;
      for (int i = 0; i < PER && m_cnt() != 0; i++) begin
         cyc();
         if (out_port != 3'b111) n++;
      end
      chk("duty held until wrap", n, 0);
      count_on(n);
      chk("duty 0x40 on count", n, 64);

      wr(3'd3, 32'h0);
      sync_cnt(0);
      count_on(n);
      chk("duty 0 on count", n, 0);

      wr(3'd3, 32'hFF);
      sync_cnt(0);
      count_on(n);
      chk("duty FF on count", n, 256);

      // DUTY write on the wrap edge: old pending value applies first
      wr(3'd3, 32'h0);
      sync_cnt(8'hFF);
      wr(3'd3, 32'h80);
      count_on(n);
      chk("wrap+write old duty", n, 0);
      count_on(n);
      chk("wrap+write new duty", n, 128);
      rd(3'd3, 32'h80, "DUTY readback");

      wr(3'd3, 32'hFF);
      sync_cnt(0);
`ifdef LED_PWM_OUTPUT_BLINK_EN
      wr(3'd4, 32'h1);
      wr(3'd5, 32'h2);
      for (int i = 0; i < 3 * PER && out_port[0]; i++) cyc();
      chk("blink fall", 32'(out_port[0]), 32'd0);
      n = 0;
      for (int i = 0; i < 3 * PER && !out_port[0]; i++) begin
         cyc();
         n++;
      end
      chk("blink low run", n, 512);
      for (int i = 0; i < 3 * PER && out_port[0]; i++) cyc();
      for (int i = 0; i < 100; i++) cyc();
      wr(3'd5, 32'h2);
      cyc();
      chk("blink restart phase", 32'(out_port), 32'h7);
      rd(3'd6, m_read(3'd6), "blink STATUS");
      rd(3'd5, 32'h2, "BLINK_PERIOD readback");
      wr(3'd4, 32'h0);
`else
      wr(3'd4, 32'h7);
      wr(3'd5, 32'h1);
      cyc();
      rd(3'd4, 32'h0, "no-blink mask read");
      rd(3'd5, 32'h0, "no-blink period read");
      chk("no-blink out_port", 32'(out_port), 32'h7);
`endif

      // reset in mid-period
      sync_cnt(8'h55);
      reset_n = 1'b0;
      cyc();
      chk("midreset out_port", 32'(out_port), 32'd0);
      rd(3'd6, 32'h100, "midreset STATUS");
      rd(3'd3, 32'hFF,  "midreset DUTY");
      rd(3'd0, 32'h0,   "midreset DATA");
      reset_n = 1'b1;

      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 7) < 2) begin
            a = 3'($urandom_range(0, 7));
            bus.address    = a;
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b0;
            case (a)
               3'd3: case ($urandom_range(0, 2))
                        0:       bus.writedata = 32'h0;
                        1:       bus.writedata = 32'hFF;
                        default: bus.writedata = $urandom;
                     endcase
               3'd5: bus.writedata = 32'($urandom_range(0, 3));
               default: bus.writedata = $urandom;
            endcase
         end else begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = $urandom;
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ~bus.chipselect;
         end
         cyc();
         bus.chipselect = 1'($urandom_range(0, 1));
         bus.write_n    = 1'b1;
         a = 3'($urandom_range(0, 7));
         rd(a, m_read(a), "random readdata");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
